// File: rtl/dec_key_sched_if.sv
// Bundle of the key-write, start and decryption-key replay signals of dec_key_sched.
// Ports: wr_en/wr_idx/wr_key (writer), start, dec_ready (reader accept),
//        dec_valid/dec_key/dec_idx (replayed key), busy, done.
interface dec_key_sched_if #(
  parameter int KEY_W = 128
);
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic [KEY_W-1:0] wr_key;
  logic             start;
  logic             dec_ready;
  logic             dec_valid;
  logic [KEY_W-1:0] dec_key;
  logic [3:0]       dec_idx;
  logic             busy;
  logic             done;

  // master: key expansion + round engine side (drives writes, start, ready)
  modport master (
    output wr_en, wr_idx, wr_key, start, dec_ready,
    input  dec_valid, dec_key, dec_idx, busy, done
  );

  // slave: the key schedule buffer itself
  modport slave (
    input  wr_en, wr_idx, wr_key, start, dec_ready,
    output dec_valid, dec_key, dec_idx, busy, done
  );
endinterface

// File: rtl/dec_key_sched.sv
// ANUBIS decryption round-key buffer: stores K[0..R], replays DK[r] = K[R-r] (theta for inner r).
// Ports: clk, reset (async active-low), bus (dec_key_sched_if.slave): write port, start,
//        dec_valid/dec_ready handshake carrying dec_key/dec_idx, busy and done status.
module dec_key_sched #(
  parameter int ROUNDS = 12,
  parameter int KEY_W  = 128
) (
  input  logic            clk,
  input  logic            reset,
  dec_key_sched_if.slave  bus
);

  localparam int         NK    = ROUNDS + 1;
  localparam logic [3:0] R_IDX = 4'(ROUNDS);

  typedef enum logic [2:0] {IDLE, FETCH, XFORM_A, XFORM_B, OUT} state_t;

  state_t           state, state_nxt;
  logic [KEY_W-1:0] mem [NK];
  logic [NK-1:0]    loaded;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] theta_q;
  logic [KEY_W-1:0] dec_key_q;
  logic [3:0]       r;
  logic             dec_valid_q;
  logic             done_q;
  logic             end_key;
  logic             start_ok;
  logic             hshake;

  // GF(2^8) doubling, reduction polynomial x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // theta: 4x4 byte matrix (row-major, byte 0 in the MSBs) times had(01,02,04,06).
  // Column j of H holds h[k^j], so b[i][j] = sum_m a[i][j^m] * h[m].
  function automatic logic [KEY_W-1:0] theta_f(input logic [KEY_W-1:0] a);
    logic [KEY_W-1:0] b;
    logic [7:0]       a0, a1, a2, a3;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a0 = a[KEY_W-1-8*(4*i + (j ^ 0)) -: 8];
        a1 = a[KEY_W-1-8*(4*i + (j ^ 1)) -: 8];
        a2 = a[KEY_W-1-8*(4*i + (j ^ 2)) -: 8];
        a3 = a[KEY_W-1-8*(4*i + (j ^ 3)) -: 8];
        b[KEY_W-1-8*(4*i + j) -: 8] = a0 ^ xt(a1) ^ xt(xt(a2)) ^ xt(xt(a3)) ^ xt(a3);
      end
    end
    return b;
  endfunction

  assign end_key  = (r == 4'd0) || (r == R_IDX);
  assign start_ok = (state == IDLE) && bus.start && (&loaded);
  assign hshake   = (state == OUT) && dec_valid_q && bus.dec_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FETCH;
      FETCH:   state_nxt = end_key ? OUT : XFORM_A;
      XFORM_A: state_nxt = XFORM_B;
      XFORM_B: state_nxt = OUT;
      OUT:     if (hshake) state_nxt = (r == R_IDX) ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Key storage has no reset; only the loaded mask gates replay.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.wr_en && bus.wr_idx <= R_IDX)
      mem[bus.wr_idx] <= bus.wr_key;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded <= '0;
    end else if (state == IDLE && bus.wr_en && bus.wr_idx <= R_IDX) begin
      loaded[bus.wr_idx] <= 1'b1;
    end
  end

  // Registered theta stage: one cycle from key_reg to theta_q.
  always_ff @(posedge clk) begin
    theta_q <= theta_f(key_reg);
  end

  // OUT spends its first cycle loading dec_key and raising dec_valid, so the
  // presented key is always a registered value; the handshake follows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r           <= '0;
      key_reg     <= '0;
      dec_key_q   <= '0;
      dec_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE:    if (start_ok) r <= '0;
        FETCH:   key_reg <= mem[R_IDX - r];
        XFORM_B: dec_key_q <= theta_q;
        OUT: begin
          if (!dec_valid_q) begin
            dec_valid_q <= 1'b1;
            if (end_key) dec_key_q <= key_reg;
          end else if (bus.dec_ready) begin
            dec_valid_q <= 1'b0;
            if (r == R_IDX) done_q <= 1'b1;
            else            r      <= r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_key   = dec_key_q;
  assign bus.dec_idx   = r;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule
